// File: rtl/ni_vc_out_buffer_pkg.sv
// Shared NoC parameters for the NI virtual-channel output buffer:
// default geometry, arbiter state encoding and small width helpers.
package ni_vc_out_buffer_pkg;

   localparam int FLIT_WIDTH_DEF = 80;
   localparam int NUM_VC_DEF     = 2;
   localparam int DEPTH_DEF      = 6;
   localparam int LOG_DEPTH_DEF  = 3;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // A single-VC build still carries a 1-bit VC field on the link.
   function automatic int vc_idx_width(input int num_vc);
      return (num_vc > 1) ? $clog2(num_vc) : 1;
   endfunction

endpackage : ni_vc_out_buffer_pkg

// File: rtl/ni_vc_fifo.sv
// Per-VC circular FIFO of {tail, flit} entries with a registered full flag.
// Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
module ni_vc_fifo
   import ni_vc_out_buffer_pkg::*;
#(
   parameter int WIDTH     = FLIT_WIDTH_DEF + 1,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int LOG_DEPTH = LOG_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic                 full_q, full_d;
   logic                 push_ok, pop_ok;

   function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
      return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + LOG_DEPTH'(1);
   endfunction

   // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
   assign push_ok = push_i && !full_q;
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
         2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == (LOG_DEPTH+1)'(DEPTH));
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // NOTE: storage is not reset; cleared pointers/counters make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = full_q;

endmodule : ni_vc_fifo

// File: rtl/ni_vc_out_buffer.sv
// NI output buffer: per-VC FIFOs, packet-locking round-robin arbiter and a
// single link output register with STALL_in backpressure.
module ni_vc_out_buffer
   import ni_vc_out_buffer_pkg::*;
#(
   parameter  int FLIT_WIDTH = FLIT_WIDTH_DEF,
   parameter  int NUM_VC     = NUM_VC_DEF,
   parameter  int DEPTH      = DEPTH_DEF,
   parameter  int LOG_DEPTH  = LOG_DEPTH_DEF,
   localparam int VC_W       = vc_idx_width(NUM_VC)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_VC*FLIT_WIDTH-1:0] data_in,
   input  logic [NUM_VC-1:0]            write,
   input  logic [NUM_VC-1:0]            tail_in,
   output logic [NUM_VC-1:0]            full,
   output logic [FLIT_WIDTH-1:0]        FLIT_out,
   output logic                         VALID_out,
   output logic [VC_W-1:0]              VC_out,
   output logic                         TAIL_out,
   input  logic                         STALL_in
);

   logic [FLIT_WIDTH:0]   head [NUM_VC];
   logic [NUM_VC-1:0]     empty;
   logic [NUM_VC-1:0]     pop;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      ni_vc_fifo #(
         .WIDTH     (FLIT_WIDTH + 1),
         .DEPTH     (DEPTH),
         .LOG_DEPTH (LOG_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (write[v]),
         .data_i  ({tail_in[v], data_in[v*FLIT_WIDTH +: FLIT_WIDTH]}),
         .pop_i   (pop[v]),
         .head_o  (head[v]),
         .empty_o (empty[v]),
         .full_o  (full[v])
      );
   end

   arb_state_e            state_q, state_d;
   logic [VC_W-1:0]       lock_vc_q, lock_vc_d;
   logic [VC_W-1:0]       last_vc_q, last_vc_d;
   logic [FLIT_WIDTH-1:0] flit_q, flit_d;
   logic [VC_W-1:0]       vc_q, vc_d;
   logic                  tail_q, tail_d;
   logic                  valid_q, valid_d;

   logic [NUM_VC-1:0]     eligible;
   logic                  grant_valid;
   logic [VC_W-1:0]       grant_vc;
   logic [FLIT_WIDTH:0]   grant_head;
   logic                  load_en;

   // While a packet is locked only its VC may win, so packets never interleave.
   always_comb begin
      eligible = ~empty;
      if (state_q == ARB_LOCKED) eligible = ~empty & (NUM_VC'(1) << lock_vc_q);
      grant_valid = 1'b0;
      grant_vc    = '0;
      for (int i = 1; i <= NUM_VC; i++) begin
         if (!grant_valid && eligible[(int'(last_vc_q) + i) % NUM_VC]) begin
            grant_valid = 1'b1;
            grant_vc    = VC_W'((int'(last_vc_q) + i) % NUM_VC);
         end
      end
   end

   assign grant_head = head[grant_vc];
   assign load_en    = !valid_q || !STALL_in;

   always_comb begin
      state_d   = state_q;
      lock_vc_d = lock_vc_q;
      last_vc_d = last_vc_q;
      flit_d    = flit_q;
      vc_d      = vc_q;
      tail_d    = tail_q;
      valid_d   = valid_q;
      pop       = '0;
      if (load_en) begin
         valid_d = grant_valid;
         if (grant_valid) begin
            pop[grant_vc] = 1'b1;
            {tail_d, flit_d} = grant_head;
            vc_d      = grant_vc;
            last_vc_d = grant_vc;
            if (grant_head[FLIT_WIDTH]) begin
               state_d = ARB_IDLE;
            end else begin
               state_d   = ARB_LOCKED;
               lock_vc_d = grant_vc;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ARB_IDLE;
         lock_vc_q <= '0;
         last_vc_q <= VC_W'(NUM_VC - 1);
         flit_q    <= '0;
         vc_q      <= '0;
         tail_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_vc_q <= lock_vc_d;
         last_vc_q <= last_vc_d;
         flit_q    <= flit_d;
         vc_q      <= vc_d;
         tail_q    <= tail_d;
         valid_q   <= valid_d;
      end
   end

   assign FLIT_out  = flit_q;
   assign VC_out    = vc_q;
   assign TAIL_out  = tail_q;
   assign VALID_out = valid_q;

endmodule : ni_vc_out_buffer

// File: tb/tb_ni_vc_out_buffer.sv
// Self-checking bench for ni_vc_out_buffer: expected link flits are queued when
// written and compared in order as the link accepts them.
module tb_ni_vc_out_buffer;

   localparam int FW   = 80;
   localparam int NV   = 2;
   localparam int DP   = 6;
   localparam int LD   = 3;
   localparam int VCW  = 1;
   localparam int WW   = VCW + 1 + FW;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NV*FW-1:0]  data_in = '0;
   logic [NV-1:0]     write = '0;
   logic [NV-1:0]     tail_in = '0;
   logic [NV-1:0]     full;
   logic [FW-1:0]     FLIT_out;
   logic              VALID_out;
   logic [VCW-1:0]    VC_out;
   logic              TAIL_out;
   logic              STALL_in = 1'b0;

   int n_vec  = 0;
   int n_miss = 0;
   int xfer_cnt = 0;
   int cyc = 0;

   logic [WW-1:0] sb [$];

   ni_vc_out_buffer #(
      .FLIT_WIDTH (FW),
      .NUM_VC     (NV),
      .DEPTH      (DP),
      .LOG_DEPTH  (LD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .write     (write),
      .tail_in   (tail_in),
      .full      (full),
      .FLIT_out  (FLIT_out),
      .VALID_out (VALID_out),
      .VC_out    (VC_out),
      .TAIL_out  (TAIL_out),
      .STALL_in  (STALL_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] mk(input int vc, input logic tail, input logic [FW-1:0] flit);
      return {VCW'(vc), tail, flit};
   endfunction

   task automatic push_exp(input int vc, input logic tail, input logic [FW-1:0] flit);
      sb.push_back(mk(vc, tail, flit));
   endtask

   // One write cycle: strobes held for exactly one rising edge.
   task automatic drive(input logic [NV-1:0] wr, input logic [NV-1:0] tl,
                        input logic [FW-1:0] d0, input logic [FW-1:0] d1);
      write   = wr;
      tail_in = tl;
      data_in = {d1, d0};
      @(posedge clk);
      #1;
      write   = '0;
      tail_in = '0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 96'(sb.size()), 96'(0));
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      write    = '0;
      tail_in  = '0;
      STALL_in = 1'b0;
      #3;
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Link monitor: pops the scoreboard on every transfer and checks held values under stall.
   logic          hold_pend = 1'b0;
   logic [WW-1:0] held_word;
   always @(negedge clk) begin
      if (!rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend)
            check("stall_hold", {95'(0), VALID_out} | (96'({VC_out, TAIL_out, FLIT_out}) << 1),
                  {95'(0), 1'b1} | (96'(held_word) << 1));
         if (VALID_out && !STALL_in) begin
            xfer_cnt++;
            if (sb.size() == 0) check("extra_flit", 96'(sb.size()), 96'(1));
            else check("flit", 96'({VC_out, TAIL_out, FLIT_out}), 96'(sb.pop_front()));
         end
         hold_pend = VALID_out && STALL_in;
         held_word = {VC_out, TAIL_out, FLIT_out};
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      int c0;
      int n;

      // Reset state, observed while rst is low and after release.
      rst = 1'b0;
      #3;
      check("rst_outputs", 96'({VALID_out, TAIL_out, VC_out, FLIT_out}), 96'(0));
      check("rst_full", 96'(full), 96'(0));
      do_reset();
      check("post_rst_valid", 96'(VALID_out), 96'(0));

      // Single tail flit on VC0: two-cycle latency, one cycle valid.
      push_exp(0, 1'b1, 80'h1);
      drive(2'b01, 2'b01, 80'h1, '0);
      @(negedge clk);
      check("lat_edge0", 96'(VALID_out), 96'(0));
      @(negedge clk);
      check("lat_edge1", 96'(VALID_out), 96'(1));
      @(negedge clk);
      check("lat_edge2", 96'(VALID_out), 96'(0));
      wait_drain("drain_single");

      // Fill VC1 behind a stalled VC0 flit held in the output register.
      do_reset();
      STALL_in = 1'b1;
      push_exp(0, 1'b1, 80'hC0);
      drive(2'b01, 2'b01, 80'hC0, '0);
      for (int k = 0; k < 7; k++) begin
         logic tl;
         tl = (k == 5);
         if (k < 6) push_exp(1, tl, 80'hB100 + 80'(k));
         drive(2'b10, {tl, 1'b0}, '0, 80'hB100 + 80'(k));
         if (k == 4 || k >= 5) check($sformatf("full_after_w%0d", k + 1), 96'(full[1]), 96'(k >= 5));
      end
      check("full_vc0", 96'(full[0]), 96'(0));
      STALL_in = 1'b0;
      wait_drain("drain_full");

      // Two packets queued before arbitration: VC0 x3 then VC1 x2, no interleave.
      do_reset();
      STALL_in = 1'b1;
      push_exp(0, 1'b0, 80'hA0);
      push_exp(0, 1'b0, 80'hA1);
      push_exp(0, 1'b1, 80'hA2);
      push_exp(1, 1'b0, 80'hB0);
      push_exp(1, 1'b1, 80'hB1);
      drive(2'b11, 2'b00, 80'hA0, 80'hB0);
      drive(2'b11, 2'b10, 80'hA1, 80'hB1);
      drive(2'b01, 2'b01, 80'hA2, '0);
      STALL_in = 1'b0;
      wait_drain("drain_pkts");

      // Continuous single-flit packets on both VCs: strict alternation, no bubbles.
      do_reset();
      x0 = xfer_cnt;
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         push_exp(0, 1'b1, 80'hD000 + 80'(k));
         push_exp(1, 1'b1, 80'hE000 + 80'(k));
         drive(2'b11, 2'b11, 80'hD000 + 80'(k), 80'hE000 + 80'(k));
      end
      n = 0;
      while (xfer_cnt < x0 + 8 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rr_xfers", 96'(xfer_cnt - x0), 96'(8));
      check("rr_cycles", 96'(cyc - c0), 96'(9));
      wait_drain("drain_rr");

      // Stall toggling every cycle through a 4-flit packet.
      do_reset();
      STALL_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_exp(0, k == 3, 80'hF0 + 80'(k));
         drive(2'b01, {1'b0, k == 3}, 80'hF0 + 80'(k), '0);
      end
      for (int k = 0; k < 12; k++) begin
         STALL_in = ~STALL_in;
         @(posedge clk);
         #1;
      end
      STALL_in = 1'b0;
      wait_drain("drain_toggle");

      // Reset in the middle of a VC0 packet, then a clean VC1 packet.
      do_reset();
      STALL_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_exp(0, k == 3, 80'h500 + 80'(k));
         drive(2'b01, {1'b0, k == 3}, 80'h500 + 80'(k), '0);
      end
      x0 = xfer_cnt;
      STALL_in = 1'b0;
      n = 0;
      while (xfer_cnt < x0 + 2 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("midpkt_xfers", 96'(xfer_cnt - x0), 96'(2));
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_outputs", 96'({VALID_out, TAIL_out, VC_out, FLIT_out}), 96'(0));
      check("async_rst_full", 96'(full), 96'(0));
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("first_cycle_idle", 96'(VALID_out), 96'(0));
      @(posedge clk);
      #1;
      push_exp(1, 1'b0, 80'h700);
      push_exp(1, 1'b1, 80'h701);
      drive(2'b10, 2'b00, '0, 80'h700);
      drive(2'b10, 2'b10, '0, 80'h701);
      wait_drain("drain_after_rst");
      repeat (6) @(posedge clk);
      #1;
      check("no_residue", 96'(VALID_out), 96'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_ni_vc_out_buffer
